pla_prog_engine: RTL and testbench

//  Runtime-programmable, pipelined two-level AND/OR PLA evaluator. Generalises the fixed espresso-derived
//  PLA blocks: cube count and I/O width are set by parameters, and the cube table lives in registers.

---
 rtl/pla_prog_engine.sv | 168 ++++++++++++++++
 tb/tb_pla_prog_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_prog_engine.sv
// pla_prog_engine
//   Runtime-programmable two-level AND/OR PLA evaluator with a 2-stage elastic
//   pipeline and a double-buffered cube table (shadow bank written by cfg_we,
//   copied to the active bank by a commit once the pipe has drained).
//
//   Optional feature macro: PLA_TERM_HIT_EN
//     defined     -> adds output term_hit, the S1 hit vector aligned with out_data
//     not defined -> port absent, no hit storage beyond S1
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     in_valid / in_ready / in_data   operand stream (N_IN literals)
//     out_valid / out_ready / out_data result stream (N_OUT outputs)
//     cfg_we / cfg_addr / cfg_data    write one cube to the shadow bank
//     cfg_commit                      request shadow->active swap
//     cfg_busy / cfg_done / cfg_err   commit status, out-of-range write flag
//     term_hit                        (PLA_TERM_HIT_EN only) per-cube hit vector
//
//   cfg_data = {en, or_mask[N_OUT-1:0], care[N_IN-1:0], val[N_IN-1:0]}
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal streaming, operands accepted
//   DRAIN | commit pending, input blocked until S1 and S2 are empty
//   SWAP  | active bank <= shadow bank, cfg_done follows next cycle
module pla_prog_engine #(
  parameter int N_IN    = 25,
  parameter int N_OUT   = 18,
  parameter int N_TERMS = 32,
  // One bit wider than a bare cube index so out-of-range addresses
  // (e.g. N_TERMS itself) are representable and can be rejected.
  localparam int TW     = $clog2(N_TERMS) + 1,
  localparam int CFG_W  = 1 + N_OUT + 2*N_IN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_data,
  input  logic               cfg_we,
  input  logic [TW-1:0]      cfg_addr,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               cfg_commit,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               cfg_err
`ifdef PLA_TERM_HIT_EN
  ,
  output logic [N_TERMS-1:0] term_hit
`endif
);

  localparam int AW       = TW - 1;
  localparam int CARE_LSB = N_IN;
  localparam int MASK_LSB = 2*N_IN;
  localparam int EN_BIT   = CFG_W - 1;
  localparam logic [TW-1:0] TERMS_LIM = TW'(N_TERMS);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SWAP  = 2'd2;

  logic [1:0]         state;
  logic [CFG_W-1:0]   active_bank [N_TERMS];
  logic [CFG_W-1:0]   shadow_bank [N_TERMS];

  logic               s1_valid;
  logic [N_TERMS-1:0] s1_hit;
  logic               s2_valid;
  logic [N_OUT-1:0]   s2_data;
  logic [N_TERMS-1:0] hit_c;
  logic [N_OUT-1:0]   or_c;
  logic               s2_adv;
  logic               accept;

  // Bank contents never change while beats are in flight (swap waits for an
  // empty pipe), so S2 can safely read or_mask from the active bank.
  always_comb begin
    hit_c = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      hit_c[t] = active_bank[t][EN_BIT] &&
                 (((in_data ^ active_bank[t][CARE_LSB-1:0]) &
                   active_bank[t][MASK_LSB-1:CARE_LSB]) == '0);
    end
  end

  always_comb begin
    or_c = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (s1_hit[t]) or_c = or_c | active_bank[t][EN_BIT-1:MASK_LSB];
    end
  end

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = (state == RUN) && (!s1_valid || s2_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign cfg_busy  = (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TERMS; t++) begin
        active_bank[t] <= '0;
        shadow_bank[t] <= '0;
      end
    end else begin
      // Copy uses the pre-write shadow; a same-cycle write still lands in shadow.
      if (state == SWAP) begin
        for (int t = 0; t < N_TERMS; t++) active_bank[t] <= shadow_bank[t];
      end
      if (cfg_we && (cfg_addr < TERMS_LIM)) shadow_bank[cfg_addr[AW-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= or_c;
      end
      if (!s1_valid || s2_adv) begin
        s1_valid <= accept;
        if (accept) s1_hit <= hit_c;
      end
    end
  end

`ifdef PLA_TERM_HIT_EN
  logic [N_TERMS-1:0] s2_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_hit <= '0;
    end else if (s2_adv && s1_valid) begin
      s2_hit <= s1_hit;
    end
  end

  assign term_hit = s2_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= (state == SWAP);
      cfg_err  <= cfg_we && (cfg_addr >= TERMS_LIM);
      case (state)
        RUN:     if (cfg_commit) state <= DRAIN;
        DRAIN:   if (!s1_valid && !s2_valid) state <= SWAP;
        SWAP:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_prog_engine.sv
// tb_pla_prog_engine
//   Directed, table-driven bench for pla_prog_engine plus hand-written
//   sequences for streaming with backpressure, commit with beats in flight,
//   out-of-range configuration writes and reset during a commit.
module tb_pla_prog_engine;

  localparam int N_IN    = 25;
  localparam int N_OUT   = 18;
  localparam int N_TERMS = 32;
  localparam int TW      = $clog2(N_TERMS) + 1;
  localparam int CFG_W   = 1 + N_OUT + 2*N_IN;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N_IN-1:0]    in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [N_OUT-1:0]   out_data;
  logic               cfg_we = 1'b0;
  logic [TW-1:0]      cfg_addr = '0;
  logic [CFG_W-1:0]   cfg_data = '0;
  logic               cfg_commit = 1'b0;
  logic               cfg_busy;
  logic               cfg_done;
  logic               cfg_err;
`ifdef PLA_TERM_HIT_EN
  logic [N_TERMS-1:0] term_hit;
`endif

  always #5 clk = ~clk;

  pla_prog_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
`ifdef PLA_TERM_HIT_EN
    ,
    .term_hit   (term_hit)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Records every result whose handshake will complete at the next rising edge.
  logic [N_OUT-1:0] mon_q[$];
  bit               mon_en = 1'b0;
  always @(negedge clk) begin
    #1;
    if (mon_en && out_valid && out_ready) mon_q.push_back(out_data);
  end

  typedef struct {
    logic [N_IN-1:0]  din;
    logic [N_OUT-1:0] dout;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [CFG_W-1:0] cube(input logic en, input logic [N_OUT-1:0] m,
                                            input logic [N_IN-1:0] care,
                                            input logic [N_IN-1:0] val);
    return {en, m, care, val};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [TW-1:0] a, input logic [CFG_W-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commit_wait(input string nm);
    int n;
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk({nm, " busy"}, 32'(cfg_busy), 32'd1);
    n = 0;
    while (!cfg_done && n < 50) begin @(negedge clk); n++; end
    chk({nm, " done"}, 32'(cfg_done), 32'd1);
    @(negedge clk);
    chk({nm, " done pulse"}, 32'(cfg_done), 32'd0);
  endtask

  task automatic run_vec(input logic [N_IN-1:0] din, input logic [N_OUT-1:0] exp,
                         input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = din; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " data"}, 32'(out_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int sent, got, n;
    bit stalled, done_seen, accepted;
    logic [N_OUT-1:0] held;

    // Bank used by the table: cube0, cube2, disabled cube3.
    vecs[0] = '{25'h1FFFFFF, 18'h0003C};
    vecs[1] = '{25'h1000400, 18'h0003D};
    vecs[2] = '{25'h0F00400, 18'h00001};
    vecs[3] = '{25'h0000000, 18'h00000};
    vecs[4] = '{25'h0000401, 18'h00000};
    vecs[5] = '{25'h10E0607, 18'h0003C};
    vecs[6] = '{25'h00004F8, 18'h00001};

    // T1 reset state and empty bank
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst cfg_done", 32'(cfg_done), 32'd0);
    chk("rst cfg_err", 32'(cfg_err), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1 valid after 1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1 valid after 2", 32'(out_valid), 32'd1);
    chk("t1 data", 32'(out_data), 32'd0);

    // T2 program cubes, shadow invisible until commit
    cfg_write(0, cube(1'b1, 18'h00001, 25'h00E0607, 25'h0000400));
    chk("t2 no err", 32'(cfg_err), 32'd0);
    cfg_write(2, cube(1'b1, 18'h0003C, 25'h1000000, 25'h1000000));
    cfg_write(3, cube(1'b0, 18'h00100, 25'h0, 25'h0));
    run_vec(25'h0000400, 18'h00000, "t2 pre-commit");
    commit_wait("t2 commit");
    run_vec(25'h0000400, 18'h00001, "t2 k");
    run_vec(25'h0000600, 18'h00000, "t2 jk");

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));

    // T3 back-to-back stream with out_ready toggling
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("t3 stall valid", 32'(out_valid), 32'd1);
        chk("t3 stall data", 32'(out_data), 32'(held));
      end
      out_ready = ((cyc % 2) == 0);
      in_valid  = (sent < 8);
      in_data   = vecs[sent % 7].din;
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("t3 res%0d", got), 32'(out_data), 32'(vecs[got % 7].dout));
        got++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = out_data;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t3 count", 32'(got), 32'd8);
    repeat (3) @(negedge clk);
    chk("t3 no dup", 32'(out_valid), 32'd0);

    // T4 commit with beats in flight
    mon_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 25'h0000400; out_ready = 1'b1;
    @(negedge clk);
    in_data = 25'h1000000;
    cfg_we = 1'b1; cfg_addr = 1; cfg_data = cube(1'b1, 18'h20000, 25'h0, 25'h0);
    @(negedge clk);
    in_data = 25'h0000000; cfg_we = 1'b0; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    done_seen = 1'b0; accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) begin
      out_ready = (k >= 2);
      #1;
      if (cfg_done) done_seen = 1'b1;
      if (cfg_busy) chk("t4 in_ready while busy", 32'(in_ready), 32'd0);
      if (in_ready) begin
        accepted = 1'b1;
        chk("t4 accept after done", 32'(done_seen), 32'd1);
      end
      if (!accepted) @(negedge clk);
    end
    chk("t4 accepted", 32'(accepted), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (mon_q.size() < 4 && n < 40) begin @(negedge clk); n++; end
    #2;
    mon_en = 1'b0;
    chk("t4 count", 32'(mon_q.size()), 32'd4);
    if (mon_q.size() >= 4) begin
      chk("t4 beat0 old bank", 32'(mon_q[0]), 32'h00001);
      chk("t4 beat1 old bank", 32'(mon_q[1]), 32'h0003C);
      chk("t4 beat2 old bank", 32'(mon_q[2]), 32'h00000);
      chk("t4 beat3 new bank", 32'(mon_q[3]), 32'h20000);
    end

    // T5 out-of-range cube write
    cfg_write(6'd32, cube(1'b1, 18'h00002, 25'h0, 25'h0));
    chk("t5 err pulse", 32'(cfg_err), 32'd1);
    @(negedge clk);
    chk("t5 err clear", 32'(cfg_err), 32'd0);
    commit_wait("t5 commit");
    run_vec(25'h0000000, 18'h20000, "t5 zero");
    run_vec(25'h0000400, 18'h20001, "t5 k");

    // T6 reset during DRAIN
    cfg_write(4, cube(1'b1, 18'h00FF0, 25'h0, 25'h0));
    @(negedge clk);
    in_valid = 1'b1; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6 draining", 32'(cfg_busy), 32'd1);
    chk("t6 stalled beat", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst out_valid", 32'(out_valid), 32'd0);
    chk("t6 rst out_data", 32'(out_data), 32'd0);
    chk("t6 rst cfg_busy", 32'(cfg_busy), 32'd0);
    chk("t6 rst cfg_done", 32'(cfg_done), 32'd0);
    chk("t6 rst cfg_err", 32'(cfg_err), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cfg_done) done_seen = 1'b1;
    end
    chk("t6 no cfg_done", 32'(done_seen), 32'd0);
    chk("t6 in_ready", 32'(in_ready), 32'd1);
    run_vec(25'h0000000, 18'h00000, "t6 active cleared");
    commit_wait("t6 commit");
    run_vec(25'h1FFFFFF, 18'h00000, "t6 shadow cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
